// File: rtl/pes_prbs_pkg.sv
// Shared definitions for the PRBS run controller: type codes, FSM encoding
// and the legal-type helper.
package pes_prbs_pkg;

    typedef enum logic [3:0] {
        PRBS7  = 4'h0,
        PRBS9  = 4'h1,
        PRBS10 = 4'h2,
        PRBS11 = 4'h3,
        PRBS15 = 4'h4,
        PRBS20 = 4'h5,
        PRBS23 = 4'h6,
        PRBS29 = 4'h7,
        PRBS31 = 4'h8
    } prbs_type_e;

    localparam logic [3:0] TYPE_MAX_DEFAULT = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INIT = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic type_legal(input logic [3:0] t, input logic [3:0] tmax);
        return (t <= tmax);
    endfunction

endpackage

// File: rtl/pes_prbs_period_meter.sv
// Period meter: captures the seed word at the end of INIT and records the
// RUN cycle count of the first recurrence of that word.
module pes_prbs_period_meter (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        capture,
    input  logic        run,
    input  logic [31:0] counter,
    input  logic [31:0] prbs_out,
    output logic [31:0] period,
    output logic        period_valid
);

    logic [31:0] seed_r;
    logic [31:0] period_r;
    logic        valid_r;
    logic        hit_s;

    // Counter 0 is the seed word itself, so it never counts as a recurrence.
    assign hit_s = run && !valid_r && (counter != 32'h0) && (prbs_out == seed_r);

    // Seed capture and first-match period register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            seed_r   <= 32'h0;
            period_r <= 32'h0;
            valid_r  <= 1'b0;
        end else if (clear) begin
            seed_r   <= 32'h0;
            period_r <= 32'h0;
            valid_r  <= 1'b0;
        end else begin
            if (capture) begin
                seed_r <= prbs_out;
            end
            if (hit_s) begin
                period_r <= counter;
                valid_r  <= 1'b1;
            end
        end
    end

    assign period       = period_r;
    assign period_valid = valid_r;

endmodule

// File: rtl/pes_prbs_ctrl.sv
// PRBS run controller: sequences init/run of an external PRBS generator and
// optionally measures its period (enabled by macro PES_PRBS_CTRL_PERIOD_EN).
module pes_prbs_ctrl
    import pes_prbs_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 4,
    parameter logic [3:0]  TYPE_MAX    = TYPE_MAX_DEFAULT
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [3:0]  cfg_type,
    input  logic [31:0] cfg_len,
    input  logic [31:0] prbs_out,
    output logic        prbs_init,
    output logic [3:0]  prbs_type,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] period,
    output logic        period_valid
);

    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

    state_e      state_r;
    state_e      state_next_s;
    logic [7:0]  init_cnt_r;
    logic [31:0] counter_r;
    logic [31:0] len_r;
    logic [3:0]  prbs_type_r;
    logic        prbs_init_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        accept_s;
    logic        reject_s;
    logic        capture_s;
    logic        len_end_s;

    assign len_end_s = (len_r != 32'h0) && (counter_r == (len_r - 32'h1));

    // Next-state and one-cycle event decode
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (type_legal(cfg_type, TYPE_MAX)) begin
                        accept_s     = 1'b1;
                        state_next_s = ST_INIT;
                    end else begin
                        reject_s     = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (stop) begin
                    state_next_s = ST_DONE;
                end else if (init_cnt_r == INIT_LAST) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN: begin
                // stop and length end together still yield one DONE
                if (stop || len_end_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            init_cnt_r  <= 8'h0;
            counter_r   <= 32'h0;
            len_r       <= 32'h0;
            prbs_type_r <= 4'h0;
            prbs_init_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            prbs_init_r <= (state_next_s != ST_RUN);
            busy_r      <= (state_next_s == ST_INIT) || (state_next_s == ST_RUN);
            done_r      <= (state_next_s == ST_DONE);
            err_r       <= reject_s;
            if (accept_s) begin
                prbs_type_r <= cfg_type;
                len_r       <= cfg_len;
            end
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + 8'h1;
            end else begin
                init_cnt_r <= 8'h0;
            end
            if (state_r == ST_RUN) begin
                if (counter_r != CNT_MAX) begin
                    counter_r <= counter_r + 32'h1;
                end
            end else begin
                counter_r <= 32'h0;
            end
        end
    end

    assign prbs_init = prbs_init_r;
    assign prbs_type = prbs_type_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

`ifdef PES_PRBS_CTRL_PERIOD_EN
    pes_prbs_period_meter u_meter (
        .clock        (clock),
        .rst_n        (rst_n),
        .clear        (accept_s),
        .capture      (capture_s),
        .run          (state_r == ST_RUN),
        .counter      (counter_r),
        .prbs_out     (prbs_out),
        .period       (period),
        .period_valid (period_valid)
    );
`else
    logic unused_meter_s;
    assign unused_meter_s = (^prbs_out) ^ capture_s;
    assign period         = 32'h0;
    assign period_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_pes_prbs_ctrl.sv
// Self-checking bench for pes_prbs_ctrl with a behavioural PRBS generator;
// expected period values follow macro PES_PRBS_CTRL_PERIOD_EN.
module tb_pes_prbs_ctrl;

`ifdef PES_PRBS_CTRL_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [3:0]  cfg_type = 4'h0;
    logic [31:0] cfg_len  = 32'h0;
    logic [31:0] prbs_out;
    logic        prbs_init;
    logic [3:0]  prbs_type;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] period;
    logic        period_valid;

    always #5 clock = ~clock;

    pes_prbs_ctrl dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .cfg_type     (cfg_type),
        .cfg_len      (cfg_len),
        .prbs_out     (prbs_out),
        .prbs_init    (prbs_init),
        .prbs_type    (prbs_type),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .period       (period),
        .period_valid (period_valid)
    );

    // Generator model: Fibonacci LFSR x^n + x^k + 1, state presented as the word
    function automatic int gen_n(input logic [3:0] t);
        case (t)
            4'h0: return 7;   4'h1: return 9;   4'h2: return 10;
            4'h3: return 11;  4'h4: return 15;  4'h5: return 20;
            4'h6: return 23;  4'h7: return 29;  default: return 31;
        endcase
    endfunction

    function automatic int gen_k(input logic [3:0] t);
        case (t)
            4'h0: return 6;   4'h1: return 5;   4'h2: return 7;
            4'h3: return 9;   4'h4: return 14;  4'h5: return 3;
            4'h6: return 18;  4'h7: return 27;  default: return 28;
        endcase
    endfunction

    function automatic logic [31:0] gen_seed(input logic [3:0] t);
        return (32'h1 << gen_n(t)) - 32'h1;
    endfunction

    function automatic logic [31:0] gen_step(input logic [3:0] t, input logic [31:0] s);
        logic fb;
        fb = s[gen_n(t) - 1] ^ s[gen_k(t) - 1];
        return ((s << 1) | {31'h0, fb}) & gen_seed(t);
    endfunction

    logic [31:0] gen_r;
    always @(posedge clock) begin
        if (prbs_init) gen_r <= gen_seed(prbs_type);
        else           gen_r <= gen_step(prbs_type, gen_r);
    end
    assign prbs_out = gen_r;

    typedef struct {
        logic [3:0]  typ;
        logic [31:0] len;
        int          stop_b;
        int          poke_b;
        int          exp_busy;
        int          exp_init;
        logic [31:0] exp_period;
        logic        exp_valid;
        logic        exp_err;
        logic [3:0]  exp_type;
    } vec_t;

    vec_t vecs [9];
    vec_t exp_q [$];

    int n_chk  = 0;
    int n_pass = 0;
    int busy_cnt   = 0;
    int init_cnt   = 0;
    int done_total = 0;
    int resp_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // Scoreboard: pop the expected record when the DUT reports done or err
    initial begin
        vec_t e;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                busy_cnt = 0;
                init_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (busy && prbs_init) init_cnt++;
                if (done) done_total++;
                if (done || err) begin
                    chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("resp%0d_err", resp_cnt), 32'(err), 32'(e.exp_err));
                        chk($sformatf("resp%0d_busy_cycles", resp_cnt), 32'(busy_cnt), 32'(e.exp_busy));
                        chk($sformatf("resp%0d_init_cycles", resp_cnt), 32'(init_cnt), 32'(e.exp_init));
                        chk($sformatf("resp%0d_period", resp_cnt), period, e.exp_period);
                        chk($sformatf("resp%0d_period_valid", resp_cnt), 32'(period_valid), 32'(e.exp_valid));
                        chk($sformatf("resp%0d_prbs_type", resp_cnt), 32'(prbs_type), 32'(e.exp_type));
                    end
                    busy_cnt = 0;
                    init_cnt = 0;
                    resp_cnt++;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int b;
        int base_resp;
        int base_done;
        @(negedge clock); #1;
        cfg_type  = v.typ;
        cfg_len   = v.len;
        start     = 1'b1;
        exp_q.push_back(v);
        base_resp = resp_cnt;
        base_done = done_total;
        b = 0;
        while (resp_cnt == base_resp && b <= v.exp_busy + 20) begin
            @(negedge clock); #1;
            start = (b == v.poke_b);
            if (start) cfg_type = 4'h9;
            stop  = (b == v.stop_b);
            b++;
        end
        start = 1'b0;
        stop  = 1'b0;
        chk($sformatf("v%0d_response_seen", idx), 32'(resp_cnt != base_resp), 32'd1);
        repeat (3) @(negedge clock);
        #1;
        chk($sformatf("v%0d_done_pulses", idx), 32'(done_total - base_done), v.exp_err ? 32'd0 : 32'd1);
        chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
    endtask

    function automatic vec_t mk(input logic [3:0] typ, input logic [31:0] len, input int stop_b,
                                input int poke_b, input int exp_busy, input int exp_init,
                                input logic [31:0] exp_period, input logic exp_valid,
                                input logic exp_err, input logic [3:0] exp_type);
        vec_t v;
        v.typ = typ; v.len = len; v.stop_b = stop_b; v.poke_b = poke_b;
        v.exp_busy = exp_busy; v.exp_init = exp_init; v.exp_period = exp_period;
        v.exp_valid = exp_valid; v.exp_err = exp_err; v.exp_type = exp_type;
        return v;
    endfunction

    initial begin
        int base_done;
        // Busy index b: 0..3 INIT, 4+N is RUN counter N
        vecs[0] = mk(4'h0, 32'd0,   204,  -1, 205,  4, PEN ? 32'd127  : 32'd0, PEN, 1'b0, 4'h0);
        vecs[1] = mk(4'h2, 32'd0,   1104, -1, 1105, 4, PEN ? 32'd1023 : 32'd0, PEN, 1'b0, 4'h2);
        vecs[2] = mk(4'h1, 32'd0,   604,  -1, 605,  4, PEN ? 32'd511  : 32'd0, PEN, 1'b0, 4'h1);
        vecs[3] = mk(4'h4, 32'd100, -1,   50, 104,  4, 32'd0, 1'b0, 1'b0, 4'h4);
        vecs[4] = mk(4'h0, 32'd200, 203,  -1, 204,  4, PEN ? 32'd127  : 32'd0, PEN, 1'b0, 4'h0);
        vecs[5] = mk(4'h9, 32'd5,   -1,   -1, 0,    0, PEN ? 32'd127  : 32'd0, PEN, 1'b1, 4'h0);
        vecs[6] = mk(4'h0, 32'd0,   1,    -1, 2,    2, 32'd0, 1'b0, 1'b0, 4'h0);
        vecs[7] = mk(4'h0, 32'd1,   -1,   -1, 5,    4, 32'd0, 1'b0, 1'b0, 4'h0);
        vecs[8] = mk(4'h3, 32'd10,  -1,   -1, 14,   4, 32'd0, 1'b0, 1'b0, 4'h3);

        #2 rst_n = 1'b0;
        #1;
        chk("rst_prbs_init", 32'(prbs_init), 32'd1);
        chk("rst_prbs_type", 32'(prbs_type), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_period", period, 32'd0);
        chk("rst_period_valid", 32'(period_valid), 32'd0);
        repeat (2) @(negedge clock);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in RUN cycle 50 aborts with no done pulse
        @(negedge clock); #1;
        cfg_type  = 4'h0;
        cfg_len   = 32'd0;
        start     = 1'b1;
        base_done = done_total;
        repeat (55) begin
            @(negedge clock); #1;
            start = 1'b0;
        end
        chk("mid_run_busy", 32'(busy), 32'd1);
        chk("mid_run_prbs_init", 32'(prbs_init), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_prbs_init", 32'(prbs_init), 32'd1);
        chk("mid_rst_prbs_type", 32'(prbs_type), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_period", period, 32'd0);
        chk("mid_rst_period_valid", 32'(period_valid), 32'd0);
        repeat (3) @(negedge clock);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        chk("post_rst_no_done", 32'(done_total - base_done), 32'd0);
        chk("post_rst_idle_busy", 32'(busy), 32'd0);

        run_vec(vecs[8], 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
